// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stop levels, stage indices, stall-vector type
// and the per-edge action encoding used by pipe_stage_reg.
package pipe_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Default width of the global stall vector
    localparam int unsigned PIPE_STALL_W = 6;

    // Upstream-stage indices into the stall vector
    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    typedef logic [PIPE_STALL_W-1:0] stall_vec_t;

    // What a stage register does on a given edge, in priority order
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_ADVANCE = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_act_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bus: upstream instruction fields in, registered fields out,
// plus the scratch channel looped back to the upstream stage.
interface pipe_stage_reg_if #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 96,
    parameter int unsigned SCR_W  = 66
);
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [SCR_W-1:0]  scr_i;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [SCR_W-1:0]  scr_o;

    // Upstream side drives the instruction and its scratch state
    modport master (
        output in_valid, in_ctrl, in_data, scr_i,
        input  out_valid, out_ctrl, out_data, scr_o
    );

    // Stage register side
    modport slave (
        input  in_valid, in_ctrl, in_data, scr_i,
        output out_valid, out_ctrl, out_data, scr_o
    );
endinterface

// File: rtl/pipe_stage_reg_perf_cnt.sv
// Saturating event counter with synchronous active-high clear.
module pipe_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] r_cnt;

    // Count events, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with stall, bubble, flush and scratch loopback.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
// STAGE must be less than STALL_W.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned     CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter int unsigned     DATA_W   = 96,
    parameter int unsigned     SCR_W    = 66,
    parameter int unsigned     STALL_W  = PIPE_STALL_W,
    parameter int unsigned     STAGE    = STG_MEM
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    pipe_stage_reg_if.slave    pipe
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        bubble_cnt
`endif
);
    logic              w_up_stop;
    logic              w_dn_stop;
    stage_act_t        w_act;

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [SCR_W-1:0]  r_scr;

    assign w_up_stop = stall[STAGE];

    // The last stage has nobody downstream to stall it
    if (STAGE + 1 < STALL_W) begin : g_dn
        assign w_dn_stop = stall[STAGE+1];
    end else begin : g_no_dn
        assign w_dn_stop = NO_STOP;
    end

    // Resolve this edge's action: flush > bubble > advance > hold
    always_comb begin
        w_act = ACT_HOLD;
        if (flush) begin
            w_act = ACT_FLUSH;
        end else if (w_up_stop && !w_dn_stop) begin
            w_act = ACT_BUBBLE;
        end else if (!w_up_stop) begin
            w_act = ACT_ADVANCE;
        end
    end

    // Stage register; scratch follows upstream only while the upstream is stopped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
            r_data  <= '0;
            r_scr   <= '0;
        end else begin
            case (w_act)
                ACT_FLUSH: begin
                    r_valid <= 1'b0;
                    r_ctrl  <= CTRL_NOP;
                    r_data  <= '0;
                    r_scr   <= '0;
                end
                ACT_BUBBLE: begin
                    r_valid <= 1'b0;
                    r_ctrl  <= CTRL_NOP;
                    r_scr   <= pipe.scr_i;
                end
                ACT_ADVANCE: begin
                    r_valid <= pipe.in_valid;
                    r_ctrl  <= pipe.in_ctrl;
                    r_data  <= pipe.in_data;
                    r_scr   <= '0;
                end
                ACT_HOLD: begin
                    r_scr   <= pipe.scr_i;
                end
                default: begin
                    r_scr   <= '0;
                end
            endcase
        end
    end

    assign pipe.out_valid = r_valid;
    assign pipe.out_ctrl  = r_ctrl;
    assign pipe.out_data  = r_data;
    assign pipe.scr_o     = r_scr;

`ifdef PIPE_STAGE_PERF_EN
    logic w_stall_inc;
    logic w_bubble_inc;

    // Flush edges are excluded from both counts
    assign w_stall_inc  = (w_up_stop == STOP) && !flush;
    assign w_bubble_inc = (w_act == ACT_BUBBLE);

    pipe_perf_cnt #(.CNT_W(32)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall_inc),
        .cnt (stall_cnt)
    );

    pipe_perf_cnt #(.CNT_W(32)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_bubble_inc),
        .cnt (bubble_cnt)
    );
`endif

endmodule
